cas_block_seq: RTL and testbench

Cassette block sequencer for the tape-output path. Given a block request (type, length, data held in a byte RAM), it drives the FSK square-wave bit generator one byte at a time: leader, sync, header, payload, checksum, trailer. It sits between the cassette-save logic/CPU-side buffer and the bit generator. It owns all byte ordering, checksum arithmetic and generator handshaking.

---
 rtl/cas_block_seq.sv | 161 ++++++++++++++++
 tb/tb_cas_block_seq.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/cas_block_seq.sv
// Cassette block sequencer: feeds leader, sync, header, payload, checksum and trailer bytes to the FSK bit generator.
// Optional trailer byte is enabled by defining CAS_TRAILER_EN.
module cas_block_seq #(
  parameter int         LEADER_LEN  = 128,
  parameter logic [7:0] LEADER_BYTE = 8'h55,
  parameter logic [7:0] SYNC_BYTE   = 8'h3C,
  parameter int         GUARD       = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       blk_start,
  input  logic [7:0] blk_type,
  input  logic [7:0] blk_len,
  output logic       data_rd,
  output logic [7:0] data_addr,
  input  logic [7:0] data_in,
  output logic       gen_start,
  output logic [7:0] gen_din,
  input  logic       gen_done,
  output logic       busy,
  output logic       blk_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_FETCH, S_CAPT, S_KICK, S_GUARDW, S_WAIT, S_FIN
  } state_t;

  typedef enum logic [2:0] {
    P_LEADER, P_SYNC, P_TYPE, P_LEN, P_DATA, P_SUM, P_TRAIL, P_END
  } phase_t;

  localparam logic [7:0] LEAD_LAST  = 8'(LEADER_LEN - 1);
  localparam logic [7:0] GUARD_INIT = 8'(GUARD);

  state_t     state, state_nx;
  phase_t     phase, phase_nx;
  logic [7:0] type_q, len_q, csum, lead_cnt, guard_cnt;
  logic       done_m, done_s;

  // gen_done comes from another clock domain; only done_s is ever looked at
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      done_m <= 1'b0;
      done_s <= 1'b0;
    end else begin
      done_m <= gen_done;
      done_s <= done_m;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (blk_start) state_nx = S_LOAD;
      S_LOAD: begin
        if (phase == P_END)       state_nx = S_FIN;
        else if (phase == P_DATA) state_nx = S_FETCH;
        else                      state_nx = S_KICK;
      end
      S_FETCH:  state_nx = S_CAPT;
      S_CAPT:   state_nx = S_KICK;
      S_KICK:   state_nx = S_GUARDW;
      S_GUARDW: if (guard_cnt == 8'd0) state_nx = S_WAIT;
      S_WAIT:   if (done_s) state_nx = S_LOAD;
      S_FIN:    state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != S_IDLE) && (state != S_FIN);
    blk_done  = (state == S_FIN);
    gen_start = (state == S_KICK);
    data_rd   = (state == S_FETCH);
  end

  // Byte-order progression, taken when the current byte has finished
  always_comb begin
    phase_nx = phase;
    case (phase)
      P_LEADER: if (lead_cnt == LEAD_LAST) phase_nx = P_SYNC;
      P_SYNC:   phase_nx = P_TYPE;
      P_TYPE:   phase_nx = P_LEN;
      P_LEN:    phase_nx = (len_q == 8'd0) ? P_SUM : P_DATA;
      P_DATA:   if (data_addr == len_q) phase_nx = P_SUM;
`ifdef CAS_TRAILER_EN
      P_SUM:    phase_nx = P_TRAIL;
      P_TRAIL:  phase_nx = P_END;
`else
      P_SUM:    phase_nx = P_END;
`endif
      default:  phase_nx = P_END;
    endcase
  end

  // data_addr doubles as the payload index; it ends at len, one past the last read
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase     <= P_LEADER;
      type_q    <= 8'h00;
      len_q     <= 8'h00;
      csum      <= 8'h00;
      lead_cnt  <= 8'h00;
      guard_cnt <= 8'h00;
      data_addr <= 8'h00;
      gen_din   <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_start) begin
            type_q    <= blk_type;
            len_q     <= blk_len;
            csum      <= 8'h00;
            lead_cnt  <= 8'h00;
            data_addr <= 8'h00;
            phase     <= P_LEADER;
          end
        end
        S_LOAD: begin
          case (phase)
            P_LEADER: gen_din <= LEADER_BYTE;
            P_SYNC:   gen_din <= SYNC_BYTE;
            P_TYPE: begin
              gen_din <= type_q;
              csum    <= csum + type_q;
            end
            P_LEN: begin
              gen_din <= len_q;
              csum    <= csum + len_q;
            end
            P_SUM:    gen_din <= csum;
`ifdef CAS_TRAILER_EN
            P_TRAIL:  gen_din <= LEADER_BYTE;
`endif
            default:  gen_din <= gen_din;
          endcase
        end
        S_CAPT: begin
          gen_din   <= data_in;
          csum      <= csum + data_in;
          data_addr <= data_addr + 8'd1;
        end
        S_KICK:   guard_cnt <= GUARD_INIT;
        S_GUARDW: if (guard_cnt != 8'd0) guard_cnt <= guard_cnt - 8'd1;
        S_WAIT: begin
          if (done_s) begin
            phase <= phase_nx;
            if (phase == P_LEADER && lead_cnt != LEAD_LAST) lead_cnt <= lead_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cas_block_seq.sv
// Scoreboard bench for cas_block_seq with LEADER_LEN=4 and a 50-cycle generator model.
// Expected byte streams follow CAS_TRAILER_EN the same way the design does.
module tb_cas_block_seq;

  localparam int LEADER_LEN = 4;
`ifdef CAS_TRAILER_EN
  localparam bit TRAILER = 1'b1;
`else
  localparam bit TRAILER = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic       blk_start;
  logic [7:0] blk_type, blk_len;
  logic       data_rd;
  logic [7:0] data_addr;
  logic [7:0] data_in = 8'h00;
  logic       gen_start;
  logic [7:0] gen_din;
  logic       gen_done;
  logic       busy, blk_done;

  logic [7:0] mem [256];
  logic [7:0] exp_bytes [$];
  logic [7:0] exp_addr [$];
  int gen_cnt = 0;
  int checks = 0, errors = 0;
  int start_cnt = 0, rd_cnt = 0, done_cnt = 0;

  cas_block_seq #(.LEADER_LEN(LEADER_LEN)) dut (
    .clk(clk), .reset_n(reset_n), .blk_start(blk_start), .blk_type(blk_type),
    .blk_len(blk_len), .data_rd(data_rd), .data_addr(data_addr), .data_in(data_in),
    .gen_start(gen_start), .gen_din(gen_din), .gen_done(gen_done), .busy(busy),
    .blk_done(blk_done)
  );

  always #5 clk = ~clk;

  // Generator drops done the cycle after a start and raises it ~50 cycles later
  always @(posedge clk) begin
    if (gen_start)      gen_cnt <= 51;
    else if (gen_cnt > 0) gen_cnt <= gen_cnt - 1;
  end
  assign gen_done = (gen_cnt == 0);

  always @(posedge clk) if (data_rd) data_in <= mem[data_addr];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: consumes expectations as the DUT presents bytes and reads
  always @(negedge clk) begin
    if (gen_start) begin
      start_cnt++;
      if (exp_bytes.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL gen_din_extra: got %0h expected none", gen_din);
      end else checkOutput("gen_din", gen_din, exp_bytes.pop_front());
    end
    if (data_rd) begin
      rd_cnt++;
      if (exp_addr.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL data_rd_extra: got addr %0h expected none", data_addr);
      end else checkOutput("data_addr", data_addr, exp_addr.pop_front());
    end
    if (blk_done) begin
      done_cnt++;
      checkOutput("busy_at_blk_done", busy, 0);
    end
  end

  task automatic pushLeader();
    for (int i = 0; i < LEADER_LEN; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'h3C);
  endtask

  task automatic pushTrailer();
    if (TRAILER) exp_bytes.push_back(8'h55);
  endtask

  task automatic applyStimulus(input logic [7:0] typ, input logic [7:0] len);
    @(negedge clk);
    blk_type  = typ;
    blk_len   = len;
    blk_start = 1'b1;
    @(negedge clk);
    blk_start = 1'b0;
  endtask

  task automatic waitBlkDone(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (5) @(posedge clk);
    #1;
    checkOutput("blk_done_count", done_cnt - d0, 1);
    checkOutput("busy_after_block", busy, 0);
    checkOutput("bytes_left", exp_bytes.size(), 0);
  endtask

  task automatic checkResetValues();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_blk_done", blk_done, 0);
    checkOutput("reset_gen_start", gen_start, 0);
    checkOutput("reset_data_rd", data_rd, 0);
    checkOutput("reset_gen_din", gen_din, 8'h00);
    checkOutput("reset_data_addr", data_addr, 8'h00);
  endtask

  initial begin
    int d0, r0, s0, n;
    reset_n   = 1'b0;
    blk_start = 1'b0;
    blk_type  = 8'h00;
    blk_len   = 8'h00;
    repeat (3) @(negedge clk);
    checkResetValues();
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Two-byte payload; also measure accept to first start latency
    mem[0] = 8'h12; mem[1] = 8'h34;
    pushLeader();
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h49);
    pushTrailer();
    exp_addr.push_back(8'd0); exp_addr.push_back(8'd1);
    d0 = done_cnt; r0 = rd_cnt;
    applyStimulus(8'h01, 8'h02);
    checkOutput("busy_after_accept", busy, 1);
    @(negedge clk);
    checkOutput("first_kick_latency", gen_start, 1);
    waitBlkDone(d0);
    checkOutput("rd_count_len2", rd_cnt - r0, 2);

    // Empty payload
    pushLeader();
    exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'hFF);
    pushTrailer();
    d0 = done_cnt; r0 = rd_cnt;
    applyStimulus(8'hFF, 8'h00);
    waitBlkDone(d0);
    checkOutput("rd_count_len0", rd_cnt - r0, 0);

    // Checksum wraps past 8 bits
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h03;
    pushLeader();
    exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h03);
    exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'h03);
    exp_bytes.push_back(8'h04);
    pushTrailer();
    for (int i = 0; i < 3; i++) exp_addr.push_back(8'(i));
    d0 = done_cnt; r0 = rd_cnt;
    applyStimulus(8'h00, 8'h03);
    waitBlkDone(d0);
    checkOutput("rd_count_len3", rd_cnt - r0, 3);

    // Request while busy must be ignored
    mem[0] = 8'h12; mem[1] = 8'h34;
    pushLeader();
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h49);
    pushTrailer();
    exp_addr.push_back(8'd0); exp_addr.push_back(8'd1);
    d0 = done_cnt; r0 = rd_cnt; s0 = start_cnt;
    applyStimulus(8'h01, 8'h02);
    n = 0;
    while (start_cnt - s0 < 2 && n < 500) begin @(posedge clk); #1; n++; end
    applyStimulus(8'hAA, 8'h05);
    checkOutput("busy_during_ignored_req", busy, 1);
    waitBlkDone(d0);
    checkOutput("rd_count_busy_req", rd_cnt - r0, 2);
    checkOutput("start_count_busy_req", start_cnt - s0, TRAILER ? 11 : 10);

    // Reset while the second payload byte is being transmitted
    pushLeader();
    exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h02);
    exp_bytes.push_back(8'h12); exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h49);
    pushTrailer();
    exp_addr.push_back(8'd0); exp_addr.push_back(8'd1);
    r0 = rd_cnt;
    applyStimulus(8'h01, 8'h02);
    n = 0;
    while (rd_cnt - r0 < 2 && n < 1000) begin @(posedge clk); #1; n++; end
    checkOutput("reached_payload", rd_cnt - r0, 2);
    repeat (10) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    checkResetValues();
    exp_bytes.delete();
    exp_addr.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Fresh block after reset must start at the leader with a cleared checksum
    mem[0] = 8'hAA;
    pushLeader();
    exp_bytes.push_back(8'h02); exp_bytes.push_back(8'h01);
    exp_bytes.push_back(8'hAA); exp_bytes.push_back(8'hAD);
    pushTrailer();
    exp_addr.push_back(8'd0);
    d0 = done_cnt; r0 = rd_cnt;
    applyStimulus(8'h02, 8'h01);
    waitBlkDone(d0);
    checkOutput("rd_count_after_reset", rd_cnt - r0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
